fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end that replaces the single-register IF stage.
- Drives the instruction bus (iaddr/idata/iready_n) and buffers up to DEPTH fetched words in a circular queue.
- Presents the oldest word to the ID stage with its PC, PC+4 and pre-decoded source-register fields.
- Supports branch redirect with full flush, and ID back-pressure via keep.

---
 rtl/fetch_queue.sv | 100 ++++++++++
 tb/tb_fetch_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: drives the instruction bus and buffers up to DEPTH
// fetched words in a circular queue, presenting the oldest with PC, PC+4 and rs1/rs2.
module fetch_queue #(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iready_n,
    input  logic [XLEN-1:0]              idata,
    output logic [XLEN-1:0]              iaddr,
    input  logic                         keep,
    input  logic                         redirect,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         inst_valid,
    output logic [XLEN-1:0]              inst,
    output logic [XLEN-1:0]              inst_pc,
    output logic [XLEN-1:0]              inst_pcp4,
    output logic [4:0]                   inst_rs1,
    output logic [4:0]                   inst_rs2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             deq, enq, space;

    assign inst_valid = valid_q[head_q];
    assign deq   = inst_valid & ~keep & ~redirect;
    assign space = (count_q < CW'(DEPTH)) | deq;
    assign enq   = ~iready_n & space & ~redirect;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        valid_d    = valid_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            valid_d    = '0;
            fetch_pc_d = redirect_pc;
        end else begin
            if (deq) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PW'(1);
            end
            // Enqueue after dequeue so a full-queue enq+deq on the same slot leaves it valid.
            if (enq) begin
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + PW'(1);
                fetch_pc_d      = fetch_pc_q + XLEN'(4);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem_q[tail_q] <= idata;
            pc_mem_q[tail_q]   <= fetch_pc_q;
        end
    end

    assign iaddr     = fetch_pc_q;
    assign count     = count_q;
    assign inst      = inst_valid ? inst_mem_q[head_q] : NOP_INST;
    assign inst_pc   = inst_valid ? pc_mem_q[head_q] : '0;
    assign inst_pcp4 = inst_valid ? pc_mem_q[head_q] + XLEN'(4) : '0;
    assign inst_rs1  = inst[19:15];
    assign inst_rs2  = inst[24:20];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: hand-derived vector table plus a queue scoreboard of
// expected head entries, with hand sequences for PC wrap and mid-cycle reset.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            rst;
    logic            iready_n, keep, redirect;
    logic [XLEN-1:0] idata, redirect_pc;
    logic [XLEN-1:0] iaddr, inst, inst_pc, inst_pcp4;
    logic            inst_valid;
    logic [4:0]      inst_rs1, inst_rs2;
    logic [CW-1:0]   count;

    logic            iready_n2, keep2, redirect2;
    logic [XLEN-1:0] idata2, redirect_pc2;
    logic [XLEN-1:0] iaddr2, inst2, inst_pc2, inst_pcp42;
    logic            inst_valid2;
    logic [4:0]      inst_rs12, inst_rs22;
    logic [CW-1:0]   count2;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .iready_n(iready_n), .idata(idata), .iaddr(iaddr),
        .keep(keep), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pcp4(inst_pcp4),
        .inst_rs1(inst_rs1), .inst_rs2(inst_rs2), .count(count)
    );

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(32'hFFFF_FFF8), .NOP_INST(32'h0000_0013)) dut2 (
        .clk(clk), .rst(rst), .iready_n(iready_n2), .idata(idata2), .iaddr(iaddr2),
        .keep(keep2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2), .inst_pcp4(inst_pcp42),
        .inst_rs1(inst_rs12), .inst_rs2(inst_rs22), .count(count2)
    );

    int nvec = 0;
    int nmis = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] m_fpc;

    typedef struct {
        logic        rst, irn, kp, rd;
        logic [31:0] rpc;
        int unsigned e_cnt;
        logic [31:0] e_iaddr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 23;
    vec_t vt[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // addi-style word whose rd/imm/rs1/rs2 fields vary with the fetch address
    function automatic logic [31:0] gen(input logic [31:0] pc);
        logic [31:0] n;
        n = (pc >> 2) + 32'd1;
        return {n[11:0], n[6:2], 3'b000, n[4:0], 7'h13};
    endfunction

    function automatic vec_t mk(input logic r, irn, kp, rd, input logic [31:0] rpc,
                                input int unsigned c, input logic [31:0] ia,
                                input logic v, input logic [31:0] pc);
        vec_t x;
        x.rst = r; x.irn = irn; x.kp = kp; x.rd = rd; x.rpc = rpc;
        x.e_cnt = c; x.e_iaddr = ia; x.e_valid = v; x.e_pc = pc;
        return x;
    endfunction

    task automatic check_sb();
        ent_t e;
        chk("sb_iaddr", iaddr, m_fpc);
        chk("sb_count", 32'(count), 32'(sb.size()));
        if (sb.size() == 0) begin
            chk("sb_valid", 32'(inst_valid), 32'd0);
            chk("sb_inst_nop", inst, 32'h0000_0013);
            chk("sb_pc", inst_pc, 32'd0);
            chk("sb_pcp4", inst_pcp4, 32'd0);
            chk("sb_rs1", 32'(inst_rs1), 32'd0);
            chk("sb_rs2", 32'(inst_rs2), 32'd0);
        end else begin
            e = sb[0];
            chk("sb_valid", 32'(inst_valid), 32'd1);
            chk("sb_inst", inst, e.inst);
            chk("sb_pc", inst_pc, e.pc);
            chk("sb_pcp4", inst_pcp4, e.pc + 32'd4);
            chk("sb_rs1", 32'(inst_rs1), 32'(e.inst[19:15]));
            chk("sb_rs2", 32'(inst_rs2), 32'(e.inst[24:20]));
        end
    endtask

    task automatic cycle(input logic r, irn, kp, rd, input logic [31:0] rpc);
        logic do_deq, do_enq, has_space;
        ent_t tmp;
        rst = r; iready_n = irn; keep = kp; redirect = rd; redirect_pc = rpc;
        idata = gen(m_fpc);
        do_deq    = (sb.size() > 0) && !kp && !rd;
        has_space = (sb.size() < DEPTH) || do_deq;
        do_enq    = !irn && has_space && !rd;
        @(posedge clk); #1;
        if (r) begin
            sb.delete();
            m_fpc = 32'h0;
        end else if (rd) begin
            sb.delete();
            m_fpc = rpc;
        end else begin
            if (do_deq) tmp = sb.pop_front();
            if (do_enq) begin
                sb.push_back('{inst: gen(m_fpc), pc: m_fpc});
                m_fpc = m_fpc + 32'd4;
            end
        end
        check_sb();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        // steady streaming
        vt[0]  = mk(0,0,0,0,0,     1, 32'd4,   1, 32'd0);
        vt[1]  = mk(0,0,0,0,0,     1, 32'd8,   1, 32'd4);
        vt[2]  = mk(0,0,0,0,0,     1, 32'd12,  1, 32'd8);
        // keep fills the queue, then release
        vt[3]  = mk(1,1,0,0,0,     0, 32'd0,   0, 32'd0);
        vt[4]  = mk(0,0,1,0,0,     1, 32'd4,   1, 32'd0);
        vt[5]  = mk(0,0,1,0,0,     2, 32'd8,   1, 32'd0);
        vt[6]  = mk(0,0,1,0,0,     3, 32'd12,  1, 32'd0);
        vt[7]  = mk(0,0,1,0,0,     4, 32'd16,  1, 32'd0);
        vt[8]  = mk(0,0,1,0,0,     4, 32'd16,  1, 32'd0);
        vt[9]  = mk(0,0,0,0,0,     4, 32'd20,  1, 32'd4);
        vt[10] = mk(0,0,0,0,0,     4, 32'd24,  1, 32'd8);
        // redirect with 3 entries, then redirect under keep
        vt[11] = mk(0,1,0,0,0,     3, 32'd24,  1, 32'd12);
        vt[12] = mk(0,0,0,1,'h200, 0, 32'h200, 0, 32'd0);
        vt[13] = mk(0,1,0,0,0,     0, 32'h200, 0, 32'd0);
        vt[14] = mk(0,0,0,0,0,     1, 32'h204, 1, 32'h200);
        vt[15] = mk(0,0,1,1,'h40,  0, 32'h40,  0, 32'd0);
        // toggling iready_n
        vt[16] = mk(1,1,0,0,0,     0, 32'd0,   0, 32'd0);
        vt[17] = mk(0,0,0,0,0,     1, 32'd4,   1, 32'd0);
        vt[18] = mk(0,1,0,0,0,     0, 32'd4,   0, 32'd0);
        vt[19] = mk(0,0,0,0,0,     1, 32'd8,   1, 32'd4);
        vt[20] = mk(0,1,0,0,0,     0, 32'd8,   0, 32'd0);
        vt[21] = mk(0,0,0,0,0,     1, 32'd12,  1, 32'd8);
        vt[22] = mk(0,1,0,0,0,     0, 32'd12,  0, 32'd0);

        rst = 1'b1; iready_n = 1'b1; keep = 1'b0; redirect = 1'b0;
        redirect_pc = '0; idata = '0;
        iready_n2 = 1'b1; keep2 = 1'b0; redirect2 = 1'b0;
        redirect_pc2 = '0; idata2 = 32'h00A0_0513;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_pcp4", inst_pcp4, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_iaddr2", iaddr2, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        m_fpc = 32'h0;

        for (int i = 0; i < NV; i++) begin
            v = vt[i];
            cycle(v.rst, v.irn, v.kp, v.rd, v.rpc);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(v.e_cnt));
            chk($sformatf("tbl%0d_iaddr", i), iaddr, v.e_iaddr);
            chk($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(v.e_valid));
            chk($sformatf("tbl%0d_pc", i), inst_pc, v.e_pc);
        end

        // fetch PC wrap on the second instance
        chk("wrap_iaddr0", iaddr2, 32'hFFFF_FFF8);
        iready_n2 = 1'b0;
        @(posedge clk); #1;
        chk("wrap_iaddr1", iaddr2, 32'hFFFF_FFFC);
        chk("wrap_pc1", inst_pc2, 32'hFFFF_FFF8);
        chk("wrap_pcp4_1", inst_pcp42, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        chk("wrap_iaddr2", iaddr2, 32'h0000_0000);
        chk("wrap_pc2", inst_pc2, 32'hFFFF_FFFC);
        chk("wrap_pcp4_2", inst_pcp42, 32'h0000_0000);
        @(posedge clk); #1;
        chk("wrap_iaddr3", iaddr2, 32'h0000_0004);
        chk("wrap_pc3", inst_pc2, 32'h0000_0000);
        chk("wrap_pcp4_3", inst_pcp42, 32'h0000_0004);
        iready_n2 = 1'b1;

        // fill to full, then reset asynchronously mid-cycle
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("full_count", 32'(count), 32'(DEPTH));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_iaddr", iaddr, 32'd0);
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_inst", inst, 32'h0000_0013);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        m_fpc = 32'h0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
